// File: rtl/lsu_stage.sv
// Load/store stage between EX and the commit register: passes ALU ops through, runs loads/stores
// over a req/gnt/rvalid handshake. Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module lsu_stage #(
    parameter int unsigned AW = 64,
    parameter int unsigned DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid_i,
    input  logic [31:0]   inst_i,
    input  logic [AW-1:0] pc_i,
    input  logic [AW-1:0] alu_res_i,
    input  logic [DW-1:0] store_data_i,
    input  logic [3:0]    mem_op_i,
    input  logic [4:0]    wb_addr_i,
    input  logic          wb_en_i,
    output logic          stall_o,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    output logic [7:0]    mem_wmask_o,
    input  logic          mem_gnt_i,
    input  logic          mem_rvalid_i,
    input  logic [DW-1:0] mem_rdata_i,
    output logic          valid_o,
    output logic [31:0]   inst_o,
    output logic [AW-1:0] pc_o,
    output logic [DW-1:0] wb_data_o,
    output logic [4:0]    wb_addr_o,
    output logic          wb_en_o,
    output logic          misalign_o,
    output logic [AW-1:0] badaddr_o
);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e        state_q, state_d;
    logic [31:0]   inst_q;
    logic [AW-1:0] pc_q, addr_q;
    logic [DW-1:0] sdata_q;
    logic [3:0]    op_q;
    logic [4:0]    wb_addr_q;
    logic          wb_en_q;
    logic          capture;

    // size code: 0 byte, 1 half, 2 word, 3 double
    function automatic logic [1:0] op_size(input logic [3:0] op);
        case (op)
            4'd2, 4'd6, 4'd9:  return 2'd1;
            4'd3, 4'd7, 4'd10: return 2'd2;
            4'd4, 4'd11:       return 2'd3;
            default:           return 2'd0;
        endcase
    endfunction

    logic       in_mem, in_misalign, trap;
    logic       st_q, sgn_q;
    logic [1:0] in_size, size_q;
    logic [2:0] lane;
    logic [7:0] base_mask;
    logic [DW-1:0] shifted, ld_data;

    assign in_mem  = (mem_op_i >= 4'd1) && (mem_op_i <= 4'd11);
    assign in_size = op_size(mem_op_i);
    always_comb begin
        unique case (in_size)
            2'd0:    in_misalign = 1'b0;
            2'd1:    in_misalign = alu_res_i[0];
            2'd2:    in_misalign = |alu_res_i[1:0];
            default: in_misalign = |alu_res_i[2:0];
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic [AW-1:0] badaddr_q, badaddr_d;
    assign trap = in_misalign;
`else
    assign trap = 1'b0;
`endif

    assign st_q   = op_q >= 4'd8;
    assign sgn_q  = (op_q >= 4'd1) && (op_q <= 4'd3);
    assign size_q = op_size(op_q);
    assign lane   = addr_q[2:0];

    always_comb begin
        unique case (size_q)
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            2'd2:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
    end

    assign shifted = mem_rdata_i >> {lane, 3'b000};
    always_comb begin
        unique case (size_q)
            2'd0:    ld_data = {{(DW-8){sgn_q & shifted[7]}}, shifted[7:0]};
            2'd1:    ld_data = {{(DW-16){sgn_q & shifted[15]}}, shifted[15:0]};
            2'd2:    ld_data = {{(DW-32){sgn_q & shifted[31]}}, shifted[31:0]};
            default: ld_data = shifted;
        endcase
    end

    logic          valid, wb_en, req, misalign;
    logic [31:0]   inst;
    logic [AW-1:0] pc;
    logic [DW-1:0] wb_data;
    logic [4:0]    wb_addr;

    always_comb begin
        state_d  = state_q;
        capture  = 1'b0;
        misalign = 1'b0;
        valid    = 1'b0;
        stall_o  = 1'b0;
        inst     = '0;
        pc       = '0;
        wb_data  = '0;
        wb_addr  = '0;
        wb_en    = 1'b0;
        req      = 1'b0;
        case (state_q)
            StIdle: begin
                if (ex_valid_i) begin
                    if (!in_mem) begin
                        valid   = 1'b1;
                        inst    = inst_i;
                        pc      = pc_i;
                        wb_data = alu_res_i;
                        wb_addr = wb_addr_i;
                        wb_en   = wb_en_i;
                    end else if (trap && in_misalign) begin
                        misalign = 1'b1;
                        valid    = 1'b1;
                        inst     = inst_i;
                        pc       = pc_i;
                        wb_addr  = wb_addr_i;
                    end else begin
                        capture = 1'b1;
                        stall_o = 1'b1;
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                req = 1'b1;
                if (mem_gnt_i && st_q) begin
                    valid   = 1'b1;
                    inst    = inst_q;
                    pc      = pc_q;
                    wb_addr = wb_addr_q;
                    state_d = StIdle;
                end else begin
                    stall_o = 1'b1;
                    if (mem_gnt_i) state_d = StWait;
                end
            end
            StWait: begin
                if (mem_rvalid_i) begin
                    valid   = 1'b1;
                    inst    = inst_q;
                    pc      = pc_q;
                    wb_data = ld_data;
                    wb_addr = wb_addr_q;
                    wb_en   = wb_en_q;
                    state_d = StIdle;
                end else begin
                    stall_o = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // Everything is forced quiet while reset is held, including a pending request.
        if (!rst) begin
            stall_o  = 1'b0;
            valid    = 1'b0;
            req      = 1'b0;
            misalign = 1'b0;
            inst     = '0;
            pc       = '0;
            wb_data  = '0;
            wb_addr  = '0;
            wb_en    = 1'b0;
        end
    end

    assign valid_o     = valid;
    assign inst_o      = inst;
    assign pc_o        = pc;
    assign wb_data_o   = wb_data;
    assign wb_addr_o   = wb_addr;
    assign wb_en_o     = wb_en & (|wb_addr);
    assign mem_req_o   = req;
    assign mem_we_o    = req & st_q;
    assign mem_addr_o  = req ? {addr_q[AW-1:3], 3'b000} : '0;
    assign mem_wdata_o = (req && st_q) ? (sdata_q << {lane, 3'b000}) : '0;
    assign mem_wmask_o = (req && st_q) ? (base_mask << lane) : 8'h00;
    assign misalign_o  = misalign;

`ifdef LSU_MISALIGN_TRAP_EN
    assign badaddr_d = misalign ? alu_res_i : badaddr_q;
    assign badaddr_o = !rst ? '0 : badaddr_d;
    always_ff @(posedge clk) begin
        if (!rst) badaddr_q <= '0;
        else      badaddr_q <= badaddr_d;
    end
`else
    assign badaddr_o = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            inst_q    <= '0;
            pc_q      <= '0;
            addr_q    <= '0;
            sdata_q   <= '0;
            op_q      <= '0;
            wb_addr_q <= '0;
            wb_en_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                inst_q    <= inst_i;
                pc_q      <= pc_i;
                addr_q    <= alu_res_i;
                sdata_q   <= store_data_i;
                op_q      <= mem_op_i;
                wb_addr_q <= wb_addr_i;
                wb_en_q   <= wb_en_i;
            end
        end
    end

endmodule

// File: tb/tb_lsu_stage.sv
// Randomized self-checking bench for lsu_stage against a byte-level reference model.
module tb_lsu_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid_i;
    logic [31:0] inst_i;
    logic [63:0] pc_i, alu_res_i, store_data_i;
    logic [3:0]  mem_op_i;
    logic [4:0]  wb_addr_i;
    logic        wb_en_i;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [63:0] mem_addr_o, mem_wdata_o;
    logic [7:0]  mem_wmask_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [63:0] mem_rdata_i;
    logic        valid_o;
    logic [31:0] inst_o;
    logic [63:0] pc_o, wb_data_o;
    logic [4:0]  wb_addr_o;
    logic        wb_en_o, misalign_o;
    logic [63:0] badaddr_o;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    lsu_stage dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid_i  (ex_valid_i),
        .inst_i      (inst_i),
        .pc_i        (pc_i),
        .alu_res_i   (alu_res_i),
        .store_data_i(store_data_i),
        .mem_op_i    (mem_op_i),
        .wb_addr_i   (wb_addr_i),
        .wb_en_i     (wb_en_i),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_wmask_o (mem_wmask_o),
        .mem_gnt_i   (mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i),
        .mem_rdata_i (mem_rdata_i),
        .valid_o     (valid_o),
        .inst_o      (inst_o),
        .pc_o        (pc_o),
        .wb_data_o   (wb_data_o),
        .wb_addr_o   (wb_addr_o),
        .wb_en_o     (wb_en_o),
        .misalign_o  (misalign_o),
        .badaddr_o   (badaddr_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic int op_bytes(input logic [3:0] op);
        case (op)
            4'd1, 4'd5, 4'd8:  return 1;
            4'd2, 4'd6, 4'd9:  return 2;
            4'd3, 4'd7, 4'd10: return 4;
            4'd4, 4'd11:       return 8;
            default:           return 0;
        endcase
    endfunction

    function automatic bit op_store(input logic [3:0] op);
        return op >= 4'd8 && op <= 4'd11;
    endfunction

    function automatic bit op_signed(input logic [3:0] op);
        return op >= 4'd1 && op <= 4'd3;
    endfunction

    function automatic logic [7:0] exp_mask(input logic [3:0] op, input logic [63:0] addr);
        logic [7:0] m = '0;
        int o = int'(addr[2:0]);
        for (int b = 0; b < op_bytes(op); b++) if (o + b < 8) m[o+b] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] exp_load(input logic [3:0] op, input logic [63:0] addr,
                                             input logic [63:0] rdata);
        logic [63:0] v = '0;
        int o = int'(addr[2:0]);
        int n = op_bytes(op);
        for (int b = 0; b < n; b++) if (o + b < 8) v[8*b +: 8] = rdata[8*(o+b) +: 8];
        if (op_signed(op) && v[8*n-1])
            for (int b = n; b < 8; b++) v[8*b +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic drive_junk();
        ex_valid_i   = 1'($urandom);
        inst_i       = $urandom;
        pc_i         = {$urandom, $urandom};
        alu_res_i    = {$urandom, $urandom};
        store_data_i = {$urandom, $urandom};
        mem_op_i     = 4'($urandom);
        wb_addr_i    = 5'($urandom);
        wb_en_i      = 1'($urandom);
    endtask

    task automatic txn(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] sdata,
                       input logic [63:0] rdata, input logic [4:0] wba, input logic wbe,
                       input int gdly, input int rdly);
        logic [31:0] inst = $urandom;
        logic [63:0] pc = {$urandom, $urandom};
        bit mem = op_bytes(op) != 0;
        bit st = op_store(op);
        logic en = wbe && (wba != 5'd0);
        @(negedge clk);
        ex_valid_i = 1'b1; inst_i = inst; pc_i = pc; alu_res_i = addr; store_data_i = sdata;
        mem_op_i = op; wb_addr_i = wba; wb_en_i = wbe; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        #1;
        if (!mem) begin
            check_eq("pass_valid", valid_o, 1);
            check_eq("pass_data", wb_data_o, addr);
            check_eq("pass_waddr", wb_addr_o, wba);
            check_eq("pass_wen", wb_en_o, en);
            check_eq("pass_inst", inst_o, inst);
            check_eq("pass_pc", pc_o, pc);
            check_eq("pass_stall", stall_o, 0);
            check_eq("pass_req", mem_req_o, 0);
            check_eq("pass_misalign", misalign_o, 0);
            return;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        if ((int'(addr[2:0]) % op_bytes(op)) != 0) begin
            check_eq("trap_misalign", misalign_o, 1);
            check_eq("trap_badaddr", badaddr_o, addr);
            check_eq("trap_valid", valid_o, 1);
            check_eq("trap_wen", wb_en_o, 0);
            check_eq("trap_stall", stall_o, 0);
            check_eq("trap_req", mem_req_o, 0);
            @(negedge clk);
            ex_valid_i = 1'b0;
            #1;
            check_eq("trap_pulse", misalign_o, 0);
            check_eq("trap_hold", badaddr_o, addr);
            check_eq("trap_noreq", mem_req_o, 0);
            return;
        end
`endif
        check_eq("acc_stall", stall_o, 1);
        check_eq("acc_valid", valid_o, 0);
        check_eq("acc_req", mem_req_o, 0);
        for (int i = 0; i <= gdly; i++) begin
            @(negedge clk);
            drive_junk();
            mem_gnt_i    = (i == gdly);
            mem_rvalid_i = 1'($urandom);
            mem_rdata_i  = {$urandom, $urandom};
            #1;
            check_eq("req_req", mem_req_o, 1);
            check_eq("req_addr", mem_addr_o, {addr[63:3], 3'b000});
            check_eq("req_we", mem_we_o, st);
            check_eq("req_mask", mem_wmask_o, st ? exp_mask(op, addr) : 8'h00);
            if (st) check_eq("req_wdata", mem_wdata_o, sdata << (8 * int'(addr[2:0])));
            if (i == gdly && st) begin
                check_eq("st_valid", valid_o, 1);
                check_eq("st_wen", wb_en_o, 0);
                check_eq("st_inst", inst_o, inst);
                check_eq("st_pc", pc_o, pc);
                check_eq("st_stall", stall_o, 0);
            end else begin
                check_eq("req_valid", valid_o, 0);
                check_eq("req_stall", stall_o, 1);
            end
        end
        if (st) return;
        for (int j = 0; j <= rdly; j++) begin
            @(negedge clk);
            drive_junk();
            mem_gnt_i    = 1'($urandom);
            mem_rvalid_i = (j == rdly);
            mem_rdata_i  = (j == rdly) ? rdata : {$urandom, $urandom};
            #1;
            check_eq("wait_req", mem_req_o, 0);
            if (j == rdly) begin
                check_eq("ld_valid", valid_o, 1);
                check_eq("ld_data", wb_data_o, exp_load(op, addr, rdata));
                check_eq("ld_wen", wb_en_o, en);
                check_eq("ld_waddr", wb_addr_o, wba);
                check_eq("ld_inst", inst_o, inst);
                check_eq("ld_pc", pc_o, pc);
                check_eq("ld_stall", stall_o, 0);
            end else begin
                check_eq("wait_valid", valid_o, 0);
                check_eq("wait_stall", stall_o, 1);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        ex_valid_i = 1'b1; inst_i = 32'h13; pc_i = 64'h100; alu_res_i = 64'h55;
        store_data_i = '0; mem_op_i = 4'd0; wb_addr_i = 5'd1; wb_en_i = 1'b1;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_valid", valid_o, 0);
        check_eq("rst_data", wb_data_o, 0);
        check_eq("rst_stall", stall_o, 0);
        check_eq("rst_req", mem_req_o, 0);
        check_eq("rst_badaddr", badaddr_o, 0);
        @(negedge clk);
        rst = 1'b1;

        txn(4'd0, 64'h1234, 64'h0, 64'h0, 5'd5, 1'b1, 0, 0);
        txn(4'd1, 64'h8000_0003, 64'h0, 64'h0000_0000_8000_0000, 5'd3, 1'b1, 0, 0);
        check_eq("lb_const", wb_data_o, 64'hFFFF_FFFF_FFFF_FF80);
        txn(4'd9, 64'h1006, 64'hBEEF, 64'h0, 5'd0, 1'b0, 3, 0);
        txn(4'd7, 64'h2004, 64'h0, 64'hF000_0000_1234_5678, 5'd7, 1'b1, 1, 2);
        check_eq("lwu_const", wb_data_o, 64'h0000_0000_F000_0000);
        txn(4'd2, 64'h10, 64'h0, 64'h0, 5'd0, 1'b1, 0, 0);
        txn(4'd3, 64'h1002, 64'h0, 64'hDEAD_BEEF_CAFE_F00D, 5'd9, 1'b1, 0, 0);

        // reset while waiting for load data
        @(negedge clk);
        ex_valid_i = 1'b1; mem_op_i = 4'd4; alu_res_i = 64'h3000; wb_addr_i = 5'd4;
        wb_en_i = 1'b1; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        #1;
        check_eq("rw_acc_stall", stall_o, 1);
        @(negedge clk);
        ex_valid_i = 1'b0; mem_gnt_i = 1'b1;
        #1;
        check_eq("rw_req", mem_req_o, 1);
        @(negedge clk);
        mem_gnt_i = 1'b0; rst = 1'b0;
        #1;
        check_eq("rw_rst_req", mem_req_o, 0);
        check_eq("rw_rst_valid", valid_o, 0);
        @(negedge clk);
        rst = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 64'h1111_2222_3333_4444;
        #1;
        check_eq("rw_late_valid", valid_o, 0);
        check_eq("rw_late_req", mem_req_o, 0);
        check_eq("rw_late_stall", stall_o, 0);
        check_eq("rw_late_wen", wb_en_o, 0);
        txn(4'd0, 64'hABCD, 64'h0, 64'h0, 5'd6, 1'b1, 0, 0);

        for (int k = 0; k < 300; k++) begin
            txn(4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
                {$urandom, $urandom}, 5'($urandom), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3));
        end

        @(negedge clk);
        ex_valid_i = 1'b0; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
        #1;
        check_eq("idle_valid", valid_o, 0);
        check_eq("idle_stall", stall_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_stage.md
Name: lsu_stage

Overview:
- Load/store unit stage between EX and the MEM/WB commit register (cmt_pipline).
- Non-memory instructions pass through with zero latency.
- Loads and stores are captured, issued to data memory over a req/gnt/rvalid handshake, and upstream is stalled until completion.
- Loads are aligned and sign/zero-extended, then presented as wb_data/wb_addr/wb_en together with inst/pc for commit.

Parameters:
- AW, 64, address width.
- DW, 64, data width. Fixed at 64; byte-lane logic assumes 8 lanes.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- ex_valid_i  in  1  EX presents a valid instruction.
- inst_i  in  32  instruction.
- pc_i  in  64  pc.
- alu_res_i  in  64  ALU result; effective address for memory ops.
- store_data_i  in  64  store source (rs2).
- mem_op_i  in  4  0 none, 1 LB, 2 LH, 3 LW, 4 LD, 5 LBU, 6 LHU, 7 LWU, 8 SB, 9 SH, 10 SW, 11 SD; 12-15 treated as none.
- wb_addr_i  in  5  destination register.
- wb_en_i  in  1  destination write enable.
- stall_o  out  1  hold EX/upstream.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1 = store.
- mem_addr_o  out  64  8-byte-aligned address.
- mem_wdata_o  out  64  lane-shifted store data.
- mem_wmask_o  out  8  byte mask.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  load data valid.
- mem_rdata_i  in  64  load data (aligned 8-byte word).
- valid_o  out  1  output slot holds a retiring instruction.
- inst_o  out  32  to commit.
- pc_o  out  64  to commit.
- wb_data_o  out  64  to commit.
- wb_addr_o  out  5  to commit.
- wb_en_o  out  1  to commit.
- misalign_o  out  1  see Optional Feature.
- badaddr_o  out  64  see Optional Feature.

Behaviour:
- FSM states: IDLE, REQ, WAIT. rst low → IDLE, internal capture registers cleared, all outputs 0 while rst low.
- IDLE, ex_valid_i=1, mem_op none:
  - Outputs are combinational pass-through: valid_o=1, wb_data_o=alu_res_i, wb_addr/en, inst, pc.
  - stall_o=0.
- IDLE, ex_valid_i=1, mem op:
  - Capture inst, pc, addr, store data, op, wb_addr, wb_en; go to REQ.
  - stall_o=1; output is a bubble (valid_o=0, wb_en_o=0, inst_o=0, pc_o=0, wb_data_o=0).
- IDLE, ex_valid_i=0: bubble, stall_o=0.
- REQ:
  - mem_req_o=1 with stable addr/we/wdata/wmask until mem_gnt_i.
  - Store and gnt: go to IDLE; that cycle valid_o=1, wb_en_o=0, inst/pc of the store, stall_o=0.
  - Load and gnt: go to WAIT, stall_o=1.
  - No gnt: stay in REQ, stall_o=1, bubble.
- WAIT:
  - mem_req_o=0.
  - mem_rvalid_i=1: valid_o=1, wb_data_o=formatted load, wb_en_o=captured wb_en, stall_o=0; go to IDLE.
  - Otherwise stall_o=1, bubble.
- Minimum latency: load 3 cycles from accept to writeback (accept T, gnt T+1, rvalid T+2). Store 2 cycles.
- Address and mask:
  - mem_addr_o={addr[63:3],3'b0}; lane offset o=addr[2:0].
  - Base mask: B 0x01, H 0x03, W 0x0F, D 0xFF.
  - mem_wmask_o = base mask << o, truncated to 8 bits (bytes beyond lane 7 dropped).
  - mem_wdata_o = store_data << (8*o).
  - Loads drive mem_wmask_o=0.
- Load format:
  - Extract (mem_rdata_i >> 8*o).
  - Size B/H/W/D; sign-extend for LB/LH/LW, zero-extend for LBU/LHU/LWU.
- If wb_addr is x0, wb_en_o is forced 0.
- mem_rvalid_i in IDLE or REQ is ignored. mem_gnt_i outside REQ is ignored.
- rst low mid-operation: FSM returns to IDLE immediately and mem_req_o drops the same cycle. A late rvalid is ignored.
- Inputs arriving while state≠IDLE are ignored; upstream holds them via stall_o.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - In IDLE, a mem op with addr not aligned to its size (H: o[0]≠0, W: o[1:0]≠0, D: o≠0) issues no request and does not enter REQ.
  - That cycle: misalign_o=1 for one cycle, badaddr_o=addr (held until the next misalign), valid_o=1, wb_en_o=0, stall_o=0.
- Undefined:
  - misalign_o=0 and badaddr_o=0 constantly.
  - Misaligned accesses are issued with truncated masks as described in Behaviour.

Test Plan:
- ADD: ex_valid, mem_op=0, alu_res=0x1234, wb_addr=5, wb_en=1 → same cycle valid_o=1, wb_data_o=0x1234, wb_addr_o=5, stall_o=0.
- LB: addr=0x8000_0003, gnt next cycle, rvalid next, rdata=0x0000_0000_8000_0000 → mem_addr_o=0x8000_0000, wb_data_o=0xFFFF_FFFF_FFFF_FF80, stall_o high for exactly 2 cycles.
- SH: addr=0x1006, data=0xBEEF, gnt delayed 3 cycles → mem_req_o held 4 cycles, wmask=0xC0, wdata=0xBEEF_0000_0000_0000, then valid_o=1, wb_en_o=0.
- LWU: addr=0x2004, rdata=0xF000_0000_1234_5678 → wb_data_o=0x0000_0000_F000_0000.
- Reset in WAIT: rst=0 for 1 cycle, then rvalid=1 → no valid_o, mem_req_o=0, FSM in IDLE, next ADD passes through.
- LSU_MISALIGN_TRAP_EN: LW at 0x1002 → no mem_req_o, misalign_o=1 for one cycle, badaddr_o=0x1002, wb_en_o=0.
